// File: rtl/vm_sel_pkg.sv
// Shared definitions for the product-select path (encoder and decoder sides).
// Button count, code width, FSM encodings and product-code constants.
package vm_sel_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam int CODE_W      = 3;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    HOLD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } sel_state_e;

  localparam logic [CODE_W-1:0] PROD_1 = 3'd0;
  localparam logic [CODE_W-1:0] PROD_2 = 3'd1;
  localparam logic [CODE_W-1:0] PROD_3 = 3'd2;
  localparam logic [CODE_W-1:0] PROD_4 = 3'd3;
  localparam logic [CODE_W-1:0] PROD_5 = 3'd4;
  localparam logic [CODE_W-1:0] PROD_6 = 3'd5;
  localparam logic [CODE_W-1:0] PROD_7 = 3'd6;
  localparam logic [CODE_W-1:0] PROD_8 = 3'd7;

  // Only meaningful for a one-hot input; callers check that first.
  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [NUM_BUTTONS-1:0] oh);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      if (oh[k]) code = code | CODE_W'(k);
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the raw product buttons, synchronous active-high reset.
module btn_sync
  import vm_sel_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] async_i,
  output logic [NUM_BUTTONS-1:0] sync_o
);

  logic [NUM_BUTTONS-1:0] meta_q;
  logic [NUM_BUTTONS-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/selection_encoder.sv
// Debounced 8-button to 3-bit product encoder with valid/ack handshake.
// Optional unacked-code timeout is built when SEL_TIMEOUT_EN is defined.
module selection_encoder
  import vm_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] btn,
  input  logic                   sel_ack,
  output logic [CODE_W-1:0]      sel_code,
  output logic                   sel_valid,
  output logic                   multi_err,
  output logic                   sel_timeout
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65536");
  end

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES);

  logic [NUM_BUTTONS-1:0] sync;
  sel_state_e             state_q, state_d;
  logic [NUM_BUTTONS-1:0] cap_q, cap_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [CODE_W-1:0]      code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   multi_q, multi_d;
  logic                   cap_onehot;

`ifdef SEL_TIMEOUT_EN
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmr_q, tmr_d;
  logic        timeout_q, timeout_d;
`endif

  btn_sync u_btn_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (btn),
    .sync_o  (sync)
  );

  // cap is never zero while in DEBOUNCE, so clearing the lowest set bit
  // leaving nothing means exactly one button is down.
  assign cap_onehot = ((cap_q & (cap_q - 1'b1)) == '0);

  // NOTE: every always_comb target gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = 1'b0;
`ifdef SEL_TIMEOUT_EN
    tmr_d     = '0;
    timeout_d = 1'b0;
`endif

    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sync != '0) begin
            cap_d   = sync;
            cnt_d   = 8'd1;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sync == cap_q) begin
            if (cnt_q == DEB_LAST) begin
              cnt_d = '0;
              if (cap_onehot) begin
                code_d  = onehot_to_code(cap_q);
                valid_d = 1'b1;
                state_d = HOLD;
              end else begin
                multi_d = 1'b1;
                state_d = WAIT_RELEASE;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else if (sync != '0) begin
            cap_d = sync;
            cnt_d = 8'd1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HOLD: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (sel_ack) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = WAIT_RELEASE;
          end
`ifdef SEL_TIMEOUT_EN
          else if (tmr_q == TMR_LAST) begin
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_RELEASE;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
`endif
        end
        WAIT_RELEASE: begin
          if (sync != '0) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST - 8'd1) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

`ifdef SEL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end
  assign sel_timeout = timeout_q;
`else
  assign sel_timeout = 1'b0;
`endif

  assign sel_code  = code_q;
  assign sel_valid = valid_q;
  assign multi_err = multi_q;

endmodule

// File: tb/tb_selection_encoder.sv
// Directed bench for selection_encoder: cycle model compared every cycle,
// plus hand-computed literal checks. Timeout cases follow SEL_TIMEOUT_EN.
module tb_selection_encoder;

  localparam int DC = 4;
  localparam int TC = 10;
`ifdef SEL_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] btn;
  logic       sel_ack;
  logic [2:0] sel_code;
  logic       sel_valid;
  logic       multi_err;
  logic       sel_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  selection_encoder #(.DEBOUNCE_CYCLES(DC), .TIMEOUT_CYCLES(TC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .btn         (btn),
    .sel_ack     (sel_ack),
    .sel_code    (sel_code),
    .sel_valid   (sel_valid),
    .multi_err   (multi_err),
    .sel_timeout (sel_timeout)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: tracks run lengths of stable samples rather than states.
  logic [7:0] m_s1 = '0, m_s2 = '0, pat = '0;
  logic [2:0] m_code = '0;
  bit         m_valid = 0, m_multi = 0, m_tout = 0, locked = 0, model_ready = 0;
  int         run = 0, quiet = 0, age = 0;

  always @(posedge clk) begin
    logic [7:0] s;
    s       = m_s2;
    m_multi = 0;
    m_tout  = 0;
    if (rst) begin
      m_valid = 0; locked = 0; run = 0; quiet = 0; age = 0;
      m_code = '0; m_s1 = '0; m_s2 = '0; pat = '0;
    end else begin
      if (!enable) begin
        m_valid = 0; locked = 0; run = 0; quiet = 0; age = 0;
      end else if (m_valid) begin
        if (sel_ack) begin
          m_valid = 0; locked = 1; quiet = 0;
        end else if (TIMEOUT_ON && age + 1 == TC) begin
          m_valid = 0; m_tout = 1; locked = 1; quiet = 0;
        end else begin
          age++;
        end
      end else if (locked) begin
        if (s == 0) begin
          quiet++;
          if (quiet == DC) begin locked = 0; quiet = 0; end
        end else begin
          quiet = 0;
        end
      end else if (s == 0) begin
        run = 0;
      end else if (run == 0 || s != pat) begin
        pat = s; run = 1;
      end else if (run < DC) begin
        run++;
      end else begin
        if ($countones(pat) == 1) begin
          m_valid = 1; m_code = 3'($clog2(pat)); age = 0;
        end else begin
          m_multi = 1; locked = 1; quiet = 0;
        end
        run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("model_valid", {7'd0, sel_valid}, {7'd0, m_valid});
      check("model_code", {5'd0, sel_code}, {5'd0, m_code});
      check("model_multi", {7'd0, multi_err}, {7'd0, m_multi});
      check("model_timeout", {7'd0, sel_timeout}, {7'd0, m_tout});
      check("pulse_exclusive", {7'd0, multi_err & sel_timeout}, 8'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input bit v, input logic [2:0] c, input bit m, input bit t);
    check({name, "_valid"}, {7'd0, sel_valid}, {7'd0, v});
    check({name, "_code"}, {5'd0, sel_code}, {5'd0, c});
    check({name, "_multi"}, {7'd0, multi_err}, {7'd0, m});
    check({name, "_timeout"}, {7'd0, sel_timeout}, {7'd0, t});
  endtask

  task automatic ack_and_release();
    sel_ack = 1'b1; tick(1); sel_ack = 1'b0;
    btn = '0; tick(10);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; btn = '0; sel_ack = 1'b0;
    tick(3);
    lit("reset", 0, 3'd0, 0, 0);
    rst = 1'b0; enable = 1'b1;
    tick(2);

    // Clean press of product 6 (code 5); valid visible after edge N+6.
    btn = 8'b0010_0000;
    tick(6); lit("press5_early", 0, 3'd0, 0, 0);
    tick(1); lit("press5_rise", 1, 3'd5, 0, 0);
    tick(5); lit("press5_hold", 1, 3'd5, 0, 0);

    // Ack, keep holding: one code per press.
    sel_ack = 1'b1; tick(1); sel_ack = 1'b0;
    lit("ack5", 0, 3'd5, 0, 0);
    tick(20); lit("held_no_repeat", 0, 3'd5, 0, 0);
    btn = '0; tick(10);
    btn = 8'b0000_0100;
    tick(7); lit("press2", 1, 3'd2, 0, 0);
    ack_and_release();

    // Multi-press: single multi_err pulse, no valid.
    btn = 8'b1000_0001;
    tick(6); lit("multi_early", 0, 3'd2, 0, 0);
    tick(1); lit("multi_pulse", 0, 3'd2, 1, 0);
    tick(1); lit("multi_end", 0, 3'd2, 0, 0);
    btn = '0; tick(10);
    btn = 8'b0000_0001;
    tick(7); lit("after_multi_idle", 1, 3'd0, 0, 0);
    ack_and_release();

    // Bounce on btn[3] never qualifies.
    btn = 8'b0000_1000; tick(2);
    btn = '0;           tick(1);
    btn = 8'b0000_1000; tick(1);
    btn = '0;           tick(12);
    lit("bounce", 0, 3'd0, 0, 0);

    // Ack while idle ignored; ack coincident with valid rise is not an accept.
    sel_ack = 1'b1; tick(3); sel_ack = 1'b0;
    lit("ack_idle", 0, 3'd0, 0, 0);
    btn = 8'b0100_0000;
    tick(6); sel_ack = 1'b1;
    tick(1); lit("ack_on_rise", 1, 3'd6, 0, 0);
    tick(1); lit("ack_next_edge", 0, 3'd6, 0, 0);
    sel_ack = 1'b0; btn = '0; tick(10);

    // Enable dropped in HOLD.
    btn = 8'b1000_0000;
    tick(7); lit("press7", 1, 3'd7, 0, 0);
    enable = 1'b0;
    tick(1); lit("disable", 0, 3'd7, 0, 0);
    btn = '0; tick(4);
    enable = 1'b1; tick(4);

    // Reset mid-debounce clears everything including the held code.
    btn = 8'b0000_0010;
    tick(4); lit("mid_debounce", 0, 3'd7, 0, 0);
    rst = 1'b1;
    tick(1); lit("reset_mid", 0, 3'd0, 0, 0);
    rst = 1'b0; btn = '0; tick(4);

    btn = 8'b0001_0000;
    tick(7); lit("press4", 1, 3'd4, 0, 0);
    if (TIMEOUT_ON) begin
      tick(9); lit("tmo_before", 1, 3'd4, 0, 0);
      tick(1); lit("tmo_pulse", 0, 3'd4, 0, 1);
      tick(1); lit("tmo_end", 0, 3'd4, 0, 0);
      btn = '0; tick(10);
      btn = 8'b0001_0000;
      tick(7); lit("press4b", 1, 3'd4, 0, 0);
      tick(9); sel_ack = 1'b1;
      tick(1); lit("ack_at_expiry", 0, 3'd4, 0, 0);
      sel_ack = 1'b0;
      tick(1); lit("ack_at_expiry_after", 0, 3'd4, 0, 0);
      btn = '0; tick(10);
    end else begin
      tick(20); lit("hold_forever", 1, 3'd4, 0, 0);
      ack_and_release();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
